ip_sdram_arbiter: RTL and testbench

- Two-port request arbiter and bus sequencer sitting directly upstream of ip_sdram.
- Port 0 serves the CPU slot and port 1 the video/DMA side.
- Each granted request is converted into the controller's merq_n/wr_n/rd_n cycle: strobe held for a fixed count, then release and post-cycle gap (write) or wait for rdata_en (read).
- Arbitration is round-robin; read data is returned to the granted port only.

---
 rtl/ip_sdram_arbiter.sv | 179 +++++++++++++++++
 tb/tb_ip_sdram_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_sdram_arbiter.sv
// ip_sdram_arbiter: round-robin two-port arbiter that sequences merq_n/wr_n/rd_n cycles for ip_sdram.
module ip_sdram_arbiter #(
  parameter int HOLD_CYCLES  = 4,
  parameter int WRITE_GAP    = 12,
  parameter int READ_GAP     = 16,
  parameter int READ_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        p0_req,
  input  logic        p0_wr,
  input  logic [22:0] p0_address,
  input  logic [7:0]  p0_wdata,
  output logic        p0_done,
  output logic [7:0]  p0_rdata,
  input  logic        p1_req,
  input  logic        p1_wr,
  input  logic [22:0] p1_address,
  input  logic [7:0]  p1_wdata,
  output logic        p1_done,
  output logic [7:0]  p1_rdata,
  input  logic        sdram_busy,
  output logic        merq_n,
  output logic [22:0] address,
  output logic        wr_n,
  output logic        rd_n,
  output logic [7:0]  wdata,
  input  logic [7:0]  rdata,
  input  logic        rdata_en,
  output logic        timeout_flag
);
  localparam int M1 = HOLD_CYCLES > WRITE_GAP ? HOLD_CYCLES : WRITE_GAP;
  localparam int M2 = READ_GAP > READ_TIMEOUT ? READ_GAP : READ_TIMEOUT;
  localparam int CW = $clog2((M1 > M2 ? M1 : M2) + 1);

  typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_STROBE, ST_WGAP, ST_RWAIT, ST_RGAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d, gnt_q, gnt_d, wr_q, wr_d, pend_q, pend_d;
  logic          merq_q, merq_d, wrn_q, wrn_d, rdn_q, rdn_d;
  logic          done0_q, done0_d, done1_q, done1_d, tmo_q, tmo_d;
  logic [22:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d, rbuf_q, rbuf_d, rd0_q, rd0_d, rd1_q, rd1_d;
  logic          gsel, gwr, fin;
  logic [7:0]    fin_data;

  assign merq_n       = merq_q;
  assign wr_n         = wrn_q;
  assign rd_n         = rdn_q;
  assign address      = addr_q;
  assign wdata        = wdata_q;
  assign p0_done      = done0_q;
  assign p1_done      = done1_q;
  assign p0_rdata     = rd0_q;
  assign p1_rdata     = rd1_q;
  assign timeout_flag = tmo_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    wr_d     = wr_q;
    pend_d   = pend_q;
    rbuf_d   = rbuf_q;
    merq_d   = merq_q;
    wrn_d    = wrn_q;
    rdn_d    = rdn_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd0_d    = rd0_q;
    rd1_d    = rd1_q;
    tmo_d    = tmo_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    fin      = 1'b0;
    fin_data = 8'h00;
    gsel     = (p0_req && p1_req) ? ~last_q : p1_req;
    gwr      = gsel ? p1_wr : p0_wr;
    case (state_q)
      ST_INIT: state_d = sdram_busy ? ST_INIT : ST_IDLE;
      // A done pulse is in flight this clock; its requester still shows req high.
      ST_IDLE: if ((p0_req || p1_req) && !done0_q && !done1_q) begin
        gnt_d   = gsel;
        last_d  = gsel;
        wr_d    = gwr;
        addr_d  = gsel ? p1_address : p0_address;
        wdata_d = gsel ? p1_wdata : p0_wdata;
        merq_d  = 1'b0;
        wrn_d   = ~gwr;
        rdn_d   = gwr;
        pend_d  = 1'b0;
        cnt_d   = '0;
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        if (rdata_en && !wr_q) begin
          pend_d = 1'b1;
          rbuf_d = rdata;
        end
        if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
          merq_d  = 1'b1;
          wrn_d   = 1'b1;
          rdn_d   = 1'b1;
          addr_d  = '0;
          wdata_d = '0;
          cnt_d   = '0;
          state_d = wr_q ? ST_WGAP : ST_RWAIT;
        end else cnt_d = cnt_q + 1'b1;
      end
      ST_WGAP: if (cnt_q == CW'(WRITE_GAP - 1)) begin
        done0_d = ~gnt_q;
        done1_d = gnt_q;
        state_d = ST_IDLE;
      end else cnt_d = cnt_q + 1'b1;
      ST_RWAIT: if (pend_q || rdata_en) begin
        fin      = 1'b1;
        fin_data = pend_q ? rbuf_q : rdata;
      end else if (cnt_q == CW'(READ_TIMEOUT - 1)) begin
        fin      = 1'b1;
        fin_data = 8'hFF;
        tmo_d    = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      ST_RGAP: if (cnt_q == CW'(READ_GAP - 1)) state_d = ST_IDLE;
               else cnt_d = cnt_q + 1'b1;
      default: state_d = ST_INIT;
    endcase
    if (fin) begin
      done0_d = ~gnt_q;
      done1_d = gnt_q;
      rd0_d   = gnt_q ? rd0_q : fin_data;
      rd1_d   = gnt_q ? fin_data : rd1_q;
      pend_d  = 1'b0;
      cnt_d   = '0;
      state_d = ST_RGAP;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      wr_q    <= 1'b0;
      pend_q  <= 1'b0;
      rbuf_q  <= '0;
      merq_q  <= 1'b1;
      wrn_q   <= 1'b1;
      rdn_q   <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      pend_q  <= pend_d;
      rbuf_q  <= rbuf_d;
      merq_q  <= merq_d;
      wrn_q   <= wrn_d;
      rdn_q   <= rdn_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      tmo_q   <= tmo_d;
    end
  end
endmodule

// File: tb/tb_ip_sdram_arbiter.sv
// tb_ip_sdram_arbiter: vector table plus per-port scoreboards against a small SDRAM responder model.
module tb_ip_sdram_arbiter;
  logic        clk, reset_n, sdram_busy;
  logic        p0_req, p0_wr, p0_done, p1_req, p1_wr, p1_done;
  logic [22:0] p0_address, p1_address, address;
  logic [7:0]  p0_wdata, p1_wdata, p0_rdata, p1_rdata, wdata, rdata;
  logic        merq_n, wr_n, rd_n, rdata_en, timeout_flag;

  ip_sdram_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .p0_req(p0_req), .p0_wr(p0_wr), .p0_address(p0_address), .p0_wdata(p0_wdata),
    .p0_done(p0_done), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_address(p1_address), .p1_wdata(p1_wdata),
    .p1_done(p1_done), .p1_rdata(p1_rdata),
    .sdram_busy(sdram_busy), .merq_n(merq_n), .address(address), .wr_n(wr_n), .rd_n(rd_n),
    .wdata(wdata), .rdata(rdata), .rdata_en(rdata_en), .timeout_flag(timeout_flag)
  );

  typedef struct {bit wr; logic [7:0] rd;} exp_t;
  typedef struct {bit p; bit wr; logic [22:0] a; logic [7:0] d; logic [7:0] exp;} vec_t;

  int ntests = 0, nfail = 0;
  exp_t q0[$], q1[$];
  logic [22:0] gaddr[$];
  logic [7:0] mem [256];
  logic [7:0] l0 = 0, l1 = 0;
  int d0cnt = 0, mlow = 0, slow = 0, dly = 0;
  bit prev = 1, early = 0, m_wr = 0;
  logic [22:0] m_addr = 0;
  exp_t e0, e1;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit p, bit wr, int a, int d, int e);
    vec_t v;
    v.p = p; v.wr = wr; v.a = 23'(a); v.d = 8'(d); v.exp = 8'(e);
    return v;
  endfunction

  // Call at a negedge; drops req on the negedge that first shows done.
  task automatic run_txn(input bit p, input bit wr, input logic [22:0] a, input logic [7:0] d,
                         input logic [7:0] exp, output int lat);
    exp_t e;
    e.wr = wr; e.rd = exp;
    if (p) begin q1.push_back(e); p1_wr = wr; p1_address = a; p1_wdata = d; p1_req = 1; end
    else   begin q0.push_back(e); p0_wr = wr; p0_address = a; p0_wdata = d; p0_req = 1; end
    lat = 0;
    do begin @(negedge clk); lat++; end while (!(p ? p1_done : p0_done) && lat < 500);
    if (!(p ? p1_done : p0_done)) begin
      ntests++; nfail++;
      $display("FAIL txn_timeout: port %0d addr %0h got no done want done", p, a);
    end
    if (p) p1_req = 0; else p0_req = 0;
  endtask

  // SDRAM responder, grant logger and strobe-width monitor
  always @(negedge clk) begin
    rdata_en = 0;
    if (!reset_n) begin
      dly = 0; prev = 1; mlow = 0; slow = 0;
    end else begin
      if (dly > 0) begin
        dly--;
        if (dly == 0) begin rdata_en = 1; rdata = mem[m_addr[7:0]]; end
      end
      if (!merq_n && prev) begin
        m_addr = address; m_wr = !wr_n;
        gaddr.push_back(address);
        if (m_wr) mem[address[7:0]] = wdata;
        else if (early) dly = 2;
      end
      if (merq_n && !prev && !m_wr && !early && m_addr != 23'h10) dly = 3;
      prev = merq_n;
      if (!merq_n) begin
        mlow++;
        if (!wr_n || !rd_n) slow++;
      end else if (mlow > 0) begin
        chk("strobe_len", mlow, 4);
        chk("rw_strobe_len", slow, 4);
        mlow = 0; slow = 0;
      end
    end
  end

  // Done scoreboard: each port pops only its own queue; the other port's rdata must hold.
  always @(negedge clk) begin
    if (!reset_n) begin
      l0 = 0; l1 = 0;
    end else begin
      if (p0_done) begin
        d0cnt++;
        if (q0.size() == 0) chk("p0_unexpected_done", 1, 0);
        else begin
          e0 = q0.pop_front();
          if (!e0.wr) l0 = e0.rd;
          chk("p0_rdata", p0_rdata, l0);
        end
        chk("p1_rdata_hold", p1_rdata, l1);
      end
      if (p1_done) begin
        if (q1.size() == 0) chk("p1_unexpected_done", 1, 0);
        else begin
          e1 = q1.pop_front();
          if (!e1.wr) l1 = e1.rd;
          chk("p1_rdata", p1_rdata, l1);
        end
        chk("p0_rdata_hold", p0_rdata, l0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tv[24];
    int lat, la, lb, k, d0;
    bit low;
    logic [22:0] ga[4];
    for (int i = 0; i < 8; i++) begin
      tv[i]      = mk(0, 1, i, 'h12 + i * 'h11, 0);
      tv[8 + i]  = mk(0, 0, i, 0, 'h12 + i * 'h11);
      tv[16 + i] = mk(0, 0, 7 - i, 0, 'h12 + (7 - i) * 'h11);
    end
    foreach (mem[i]) mem[i] = 0;
    ga[0] = 23'h0; ga[1] = 23'h20; ga[2] = 23'h1; ga[3] = 23'h7;
    reset_n = 0; sdram_busy = 1; rdata = 0; rdata_en = 0;
    p0_req = 0; p0_wr = 0; p0_address = 0; p0_wdata = 0;
    p1_req = 0; p1_wr = 0; p1_address = 0; p1_wdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_merq_n", merq_n, 1);
    chk("rst_wr_n", wr_n, 1);
    chk("rst_rd_n", rd_n, 1);
    chk("rst_address", address, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_done", {p1_done, p0_done}, 0);
    chk("rst_rdata", {p1_rdata, p0_rdata}, 0);
    chk("rst_timeout", timeout_flag, 0);
    reset_n = 1;
    // Write requested during controller init, granted one clock after busy falls
    fork
      run_txn(0, 1, 23'h3, 8'h45, 8'h00, lat);
      begin
        low = 0;
        repeat (20) begin @(negedge clk); if (!merq_n) low = 1; end
        chk("busy_no_strobe", low, 0);
        sdram_busy = 0;
        @(negedge clk);
        chk("merq_n_idle_clk", merq_n, 1);
        @(negedge clk);
        chk("t1_merq_n", merq_n, 0);
        chk("t1_wr_n", wr_n, 0);
        chk("t1_rd_n", rd_n, 1);
        chk("t1_address", address, 23'h3);
        chk("t1_wdata", wdata, 8'h45);
        k = 0;
        while (!p0_done && k < 100) begin @(negedge clk); k++; end
        chk("t1_done_latency", k, 16);
      end
    join
    repeat (5) @(negedge clk);
    for (int i = 0; i < 24; i++) run_txn(tv[i].p, tv[i].wr, tv[i].a, tv[i].d, tv[i].exp, lat);
    // Read data strobed while still in the strobe phase
    repeat (20) @(negedge clk);
    early = 1;
    run_txn(0, 0, 23'h4, 8'h00, 8'h56, lat);
    early = 0;
    chk("early_rdata_latency", lat, 6);
    // Contention: last grant was port 1 after this write, so port 0 wins first
    repeat (20) @(negedge clk);
    run_txn(1, 1, 23'h20, 8'h5A, 8'h00, lat);
    repeat (5) @(negedge clk);
    gaddr.delete();
    fork
      begin run_txn(0, 0, 23'h0, 8'h00, 8'h12, la); run_txn(0, 0, 23'h1, 8'h00, 8'h23, la); end
      begin run_txn(1, 0, 23'h20, 8'h00, 8'h5A, lb); run_txn(1, 0, 23'h7, 8'h00, 8'h89, lb); end
    join
    chk("rr_grant_count", gaddr.size(), 4);
    for (int i = 0; i < 4 && i < gaddr.size(); i++) chk($sformatf("rr_grant_%0d", i), gaddr[i], ga[i]);
    // Short port-0 pulse while port 1's write sits in its post-write gap
    repeat (20) @(negedge clk);
    d0 = d0cnt;
    gaddr.delete();
    fork
      run_txn(1, 1, 23'h30, 8'h77, 8'h00, lb);
      begin
        k = 0;
        while (wr_n && k < 50) begin @(negedge clk); k++; end
        while (!wr_n && k < 50) begin @(negedge clk); k++; end
        repeat (2) @(negedge clk);
        p0_wr = 0; p0_address = 23'h5; p0_req = 1;
        @(negedge clk);
        p0_req = 0;
      end
    join
    repeat (40) @(negedge clk);
    chk("pulse_no_p0_done", d0cnt, d0);
    chk("pulse_grants", gaddr.size(), 1);
    // Read that never gets rdata_en
    run_txn(1, 0, 23'h10, 8'h00, 8'hFF, lat);
    chk("timeout_latency", lat, 69);
    chk("timeout_flag_set", timeout_flag, 1);
    repeat (20) @(negedge clk);
    run_txn(0, 0, 23'h2, 8'h00, 8'h34, lat);
    chk("timeout_flag_sticky", timeout_flag, 1);
    chk("timeout_p1_rdata_hold", p1_rdata, 8'hFF);
    // Reset two clocks into a read strobe
    repeat (20) @(negedge clk);
    d0 = d0cnt;
    p0_wr = 0; p0_address = 23'h1; p0_req = 1;
    k = 0;
    do begin @(negedge clk); k++; end while (merq_n && k < 10);
    @(negedge clk);
    #2 reset_n = 0;
    #1;
    chk("arst_merq_n", merq_n, 1);
    chk("arst_rd_n", rd_n, 1);
    chk("arst_address", address, 0);
    p0_req = 0;
    repeat (3) @(negedge clk);
    chk("arst_no_done", d0cnt, d0);
    chk("arst_timeout_clr", timeout_flag, 0);
    chk("arst_rdata_clr", {p1_rdata, p0_rdata}, 0);
    reset_n = 1;
    @(negedge clk);
    run_txn(0, 1, 23'h0, 8'hA5, 8'h00, lat);
    chk("post_rst_write_latency", lat, 17);
    repeat (5) @(negedge clk);
    run_txn(0, 0, 23'h0, 8'h00, 8'hA5, lat);
    repeat (20) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
